cp0_reg_ext: RTL and testbench

Parametrised second-generation CP0 register file for the MIPS32 core. It adds configurable hardware-interrupt width, a Count prescaler and BadVAddr. It also adds in-block exception commit: EPC, Cause, Status.EXL and BadVAddr update, plus eret handling. The block is written from the MEM-stage exception logic and read by MEM/WB forwarding and the ctrl unit.

---
 rtl/cp0_reg_ext_pkg.sv | 61 ++++++
 rtl/cp0_reg_ext_if.sv | 24 ++
 rtl/cp0_timer.sv | 49 ++++
 rtl/cp0_reg_ext.sv | 145 ++++++++++++++
 tb/tb_cp0_reg_ext.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_reg_ext_pkg.sv
// Shared CP0 definitions: register numbers, exception type encodings, ExcCode values,
// Status/Cause bit positions, reset constants and the excepttype->ExcCode mapping.
package cp0_reg_ext_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;
    localparam logic [4:0] EXCCODE_TR   = 5'd13;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int CAUSE_BD       = 31;
    localparam int CAUSE_IV       = 23;
    localparam int CAUSE_WP       = 22;
    localparam int CAUSE_IP7      = 15;
    localparam int CAUSE_IP_HW_LO = 10;
    localparam int CAUSE_IP_LO    = 8;
    localparam int CAUSE_EXC_LO   = 2;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;

    // Unrecognised nonzero codes are reported as reserved instruction.
    function automatic logic [4:0] exccode_of(input logic [31:0] excepttype);
        logic [4:0] code;
        code = EXCCODE_RI;
        case (excepttype)
            EXC_INT:  code = EXCCODE_INT;
            EXC_ADEL: code = EXCCODE_ADEL;
            EXC_ADES: code = EXCCODE_ADES;
            EXC_SYS:  code = EXCCODE_SYS;
            EXC_RI:   code = EXCCODE_RI;
            EXC_OV:   code = EXCCODE_OV;
            EXC_TR:   code = EXCCODE_TR;
            default:  code = EXCCODE_RI;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_reg_ext_if.sv
// mtc0/mfc0 and exception-commit bus between the MEM stage (master) and CP0 (slave).
interface cp0_reg_ext_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] badvaddr_i;

    modport master (
        output we_i, waddr_i, raddr_i, data_i,
        output excepttype_i, current_inst_addr_i, is_in_delayslot_i, badvaddr_i,
        input  data_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, data_i,
        input  excepttype_i, current_inst_addr_i, is_in_delayslot_i, badvaddr_i,
        output data_o
    );
endinterface

// File: rtl/cp0_timer.sv
// Count prescaler, Count/Compare registers and the sticky timer interrupt.
// All state updates on one edge; writes are always accepted (no backpressure).
module cp0_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            // A Count load restarts the prescaler and swallows this cycle's increment.
            if (count_we) begin
                count <= wdata;
                presc <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (compare != 32'd0 && count == compare) begin
                timer_int <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/cp0_reg_ext.sv
// CP0 register file with in-block exception/eret commit; reads are combinational,
// writes and commits take effect on the next edge; the block never stalls its writers.
module cp0_reg_ext
    import cp0_reg_ext_pkg::*;
#(
    parameter int          N_HW_INT     = 6,
    parameter int          COUNT_DIV    = 1,
    parameter int          TIMER_ON_IP7 = 1,
    parameter logic [31:0] PRID_VAL     = 32'h004c0102,
    parameter logic [31:0] CONFIG_VAL   = 32'h00008000
) (
    input  logic                clk,
    input  logic                rst,
    cp0_reg_ext_if.slave        bus,
    input  logic [N_HW_INT-1:0] int_i,
    output logic [31:0]         count_o,
    output logic [31:0]         compare_o,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o,
    output logic [31:0]         badvaddr_o,
    output logic [31:0]         config_o,
    output logic [31:0]         prid_o,
    output logic                timer_int_o,
    output logic                int_pending_o
);
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic [5:0]  hw_ip;
    logic        exc_commit;
    logic        eret;
    logic        count_we;
    logic        compare_we;

    assign count_we   = bus.we_i && (bus.waddr_i == REG_COUNT);
    assign compare_we = bus.we_i && (bus.waddr_i == REG_COMPARE);
    assign exc_commit = (bus.excepttype_i != EXC_NONE) && (bus.excepttype_i != EXC_ERET);
    assign eret       = (bus.excepttype_i == EXC_ERET);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (bus.data_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    always_comb begin
        hw_ip = '0;
        hw_ip[N_HW_INT-1:0] = int_i;
    end

    // mtc0 is applied first, then exception/eret overrides only the fields it owns.
    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        badv_d   = badv_q;

        cause_d[CAUSE_IP_HW_LO +: 6] = hw_ip;

        if (bus.we_i) begin
            case (bus.waddr_i)
                REG_STATUS: status_d = bus.data_i;
                REG_EPC:    epc_d    = bus.data_i;
                REG_CAUSE: begin
                    cause_d[CAUSE_IP_LO +: 2] = bus.data_i[CAUSE_IP_LO +: 2];
                    cause_d[CAUSE_IV]         = bus.data_i[CAUSE_IV];
                    cause_d[CAUSE_WP]         = bus.data_i[CAUSE_WP];
                end
                default: ;
            endcase
        end

        if (exc_commit) begin
            if (!status_q[STATUS_EXL]) begin
                epc_d = bus.is_in_delayslot_i ? (bus.current_inst_addr_i - 32'd4)
                                              : bus.current_inst_addr_i;
                cause_d[CAUSE_BD] = bus.is_in_delayslot_i;
            end
            status_d[STATUS_EXL]        = 1'b1;
            cause_d[CAUSE_EXC_LO +: 5] = exccode_of(bus.excepttype_i);
            if (bus.excepttype_i == EXC_ADEL || bus.excepttype_i == EXC_ADES) begin
                badv_d = bus.badvaddr_i;
            end
        end else if (eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RST;
            cause_q  <= '0;
            epc_q    <= '0;
            badv_q   <= '0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            badv_q   <= badv_d;
        end
    end

    // The timer is merged into IP7 at the output so it is visible as soon as it is set.
    always_comb begin
        cause_o = cause_q;
        if (TIMER_ON_IP7 != 0) begin
            cause_o[CAUSE_IP7] = cause_q[CAUSE_IP7] | timer_int_o;
        end
    end

    assign status_o   = status_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badv_q;
    assign config_o   = CONFIG_VAL;
    assign prid_o     = PRID_VAL;

    assign int_pending_o = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                         & (|(cause_o[15:8] & status_q[15:8]));

    always_comb begin
        bus.data_o = '0;
        if (!rst) begin
            case (bus.raddr_i)
                REG_BADVADDR: bus.data_o = badv_q;
                REG_COUNT:    bus.data_o = count_o;
                REG_COMPARE:  bus.data_o = compare_o;
                REG_STATUS:   bus.data_o = status_q;
                REG_CAUSE:    bus.data_o = cause_o;
                REG_EPC:      bus.data_o = epc_q;
                REG_PRID:     bus.data_o = PRID_VAL;
                REG_CONFIG:   bus.data_o = CONFIG_VAL;
                default:      bus.data_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cp0_reg_ext.sv
// Directed plus randomized check of cp0_reg_ext against a cycle-level behavioural model.
module tb_cp0_reg_ext;
    localparam int          DIV    = 4;
    localparam logic [31:0] PRID   = 32'h004c0102;
    localparam logic [31:0] CONFIG = 32'h00008000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  int_in = '0;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, config_o, prid_o;
    logic        timer_int_o, int_pending_o;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_base, m_compare, m_status, m_epc, m_badv;
    int unsigned m_ticks;
    logic        m_timer, m_bd, m_iv, m_wp;
    logic [5:0]  m_ip_hw;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_exc;

    cp0_reg_ext_if bus ();

    cp0_reg_ext #(
        .N_HW_INT     (6),
        .COUNT_DIV    (DIV),
        .TIMER_ON_IP7 (1),
        .PRID_VAL     (PRID),
        .CONFIG_VAL   (CONFIG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .int_i         (int_in),
        .count_o       (count_o),
        .compare_o     (compare_o),
        .status_o      (status_o),
        .cause_o       (cause_o),
        .epc_o         (epc_o),
        .badvaddr_o    (badvaddr_o),
        .config_o      (config_o),
        .prid_o        (prid_o),
        .timer_int_o   (timer_int_o),
        .int_pending_o (int_pending_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks / DIV);
    endfunction

    function automatic logic [4:0] m_code(input logic [31:0] et);
        case (et)
            32'h1:   return 5'd0;
            32'h4:   return 5'd4;
            32'h5:   return 5'd5;
            32'h8:   return 5'd8;
            32'hc:   return 5'd12;
            32'hd:   return 5'd13;
            default: return 5'd10;
        endcase
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = '0;
        c[31]    = m_bd;
        c[23]    = m_iv;
        c[22]    = m_wp;
        c[15:10] = m_ip_hw;
        c[15]    = m_ip_hw[5] | m_timer;
        c[9:8]   = m_ip_sw;
        c[6:2]   = m_exc;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (rst) return 32'h0;
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            5'd16:   return CONFIG;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] cur, et;
        logic        wr, old_exl;
        cur     = m_count();
        et      = bus.excepttype_i;
        wr      = bus.we_i;
        old_exl = m_status[1];
        if (rst) begin
            m_base = 0; m_ticks = 0; m_compare = 0; m_timer = 0;
            m_status = 32'h1000_0000; m_epc = 0; m_badv = 0;
            m_bd = 0; m_iv = 0; m_wp = 0; m_ip_hw = 0; m_ip_sw = 0; m_exc = 0;
        end else begin
            if (wr && bus.waddr_i == 5'd11) m_timer = 1'b0;
            else if (m_compare != 0 && cur == m_compare) m_timer = 1'b1;
            if (wr && bus.waddr_i == 5'd11) m_compare = bus.data_i;
            if (wr && bus.waddr_i == 5'd9) begin
                m_base = bus.data_i; m_ticks = 0;
            end else begin
                m_ticks++;
            end
            m_ip_hw = int_in;
            if (wr && bus.waddr_i == 5'd12) m_status = bus.data_i;
            if (wr && bus.waddr_i == 5'd14) m_epc = bus.data_i;
            if (wr && bus.waddr_i == 5'd13) begin
                m_ip_sw = bus.data_i[9:8]; m_iv = bus.data_i[23]; m_wp = bus.data_i[22];
            end
            if (et != 0 && et != 32'he) begin
                if (!old_exl) begin
                    m_epc = bus.is_in_delayslot_i ? bus.current_inst_addr_i - 4
                                                  : bus.current_inst_addr_i;
                    m_bd  = bus.is_in_delayslot_i;
                end
                m_status[1] = 1'b1;
                m_exc = m_code(et);
                if (et == 32'h4 || et == 32'h5) m_badv = bus.badvaddr_i;
            end else if (et == 32'he) begin
                m_status[1] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] c;
        c = m_cause();
        chk("count", count_o, m_count());
        chk("compare", compare_o, m_compare);
        chk("status", status_o, m_status);
        chk("cause", cause_o, c);
        chk("epc", epc_o, m_epc);
        chk("badvaddr", badvaddr_o, m_badv);
        chk("config", config_o, CONFIG);
        chk("prid", prid_o, PRID);
        chk("timer_int", {31'b0, timer_int_o}, {31'b0, m_timer});
        chk("int_pending", {31'b0, int_pending_o},
            {31'b0, m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]))});
        chk("data_o", bus.data_o, m_read(bus.raddr_i));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
        cycle();
        bus.we_i = 1'b0;
    endtask

    task automatic exc(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bv);
        bus.excepttype_i = et; bus.current_inst_addr_i = pc;
        bus.is_in_delayslot_i = ds; bus.badvaddr_i = bv;
        cycle();
        bus.excepttype_i = 32'h0; bus.is_in_delayslot_i = 1'b0;
    endtask

    logic [31:0] ets [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h4,
                              32'h5, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h7};

    initial begin
        bus.we_i = 0; bus.waddr_i = 0; bus.raddr_i = 5'd12; bus.data_i = 0;
        bus.excepttype_i = 0; bus.current_inst_addr_i = 0;
        bus.is_in_delayslot_i = 0; bus.badvaddr_i = 0;
        m_base = 0; m_ticks = 0; m_compare = 0; m_timer = 0; m_status = 0;
        m_epc = 0; m_badv = 0; m_bd = 0; m_iv = 0; m_wp = 0;
        m_ip_hw = 0; m_ip_sw = 0; m_exc = 0;

        // reset
        cycle(); cycle();
        chk("rst_status", status_o, 32'h1000_0000);
        rst = 1'b0;

        // prescaled count
        repeat (40) cycle();
        chk("count_after_40", count_o, 32'd10);
        bus.raddr_i = 5'd15; #1;
        chk("rd_prid", bus.data_o, PRID);
        bus.raddr_i = 5'd3; #1;
        chk("rd_unmapped", bus.data_o, 32'h0);
        bus.raddr_i = 5'd13;

        // timer match, stickiness, clear by Compare write
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        for (int i = 0; i < 64 && count_o != 32'd5; i++) cycle();
        chk("count_reach_5", count_o, 32'd5);
        chk("timer_before", {31'b0, timer_int_o}, 32'd0);
        cycle();
        chk("timer_rise", {31'b0, timer_int_o}, 32'd1);
        repeat (30) cycle();
        chk("timer_sticky", {31'b0, timer_int_o}, 32'd1);
        chk("ip7_timer", {31'b0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        chk("timer_clear", {31'b0, timer_int_o}, 32'd0);

        // hardware interrupt and masking by EXL
        int_in = 6'b000001;
        mtc0(5'd12, 32'h0000_FF01);
        chk("ip2", {31'b0, cause_o[10]}, 32'd1);
        chk("pending_on", {31'b0, int_pending_o}, 32'd1);
        exc(32'h1, 32'h400, 1'b0, 32'h0);
        chk("pending_exl", {31'b0, int_pending_o}, 32'd0);
        exc(32'he, 32'h0, 1'b0, 32'h0);
        int_in = 6'b0;

        // delay-slot exception, nested exception, eret
        bus.raddr_i = 5'd14;
        exc(32'h8, 32'h100, 1'b1, 32'h0);
        chk("epc_ds", epc_o, 32'hFC);
        chk("bd", {31'b0, cause_o[31]}, 32'd1);
        chk("exccode_sys", {27'b0, cause_o[6:2]}, 32'd8);
        chk("exl_set", {31'b0, status_o[1]}, 32'd1);
        exc(32'ha, 32'h300, 1'b0, 32'h0);
        chk("epc_held", epc_o, 32'hFC);
        exc(32'he, 32'h0, 1'b0, 32'h0);
        chk("exl_clear", {31'b0, status_o[1]}, 32'd0);

        // address error and read-only BadVAddr
        exc(32'h4, 32'h500, 1'b0, 32'h1003);
        chk("badvaddr", badvaddr_o, 32'h1003);
        chk("exccode_adel", {27'b0, cause_o[6:2]}, 32'd4);
        exc(32'he, 32'h0, 1'b0, 32'h0);
        mtc0(5'd8, 32'hDEAD_BEEF);
        chk("badvaddr_ro", badvaddr_o, 32'h1003);

        // exception beats same-cycle mtc0 EPC
        bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'hAAAA;
        exc(32'hc, 32'h200, 1'b0, 32'h0);
        bus.we_i = 1'b0;
        chk("epc_exc_wins", epc_o, 32'h200);
        exc(32'he, 32'h0, 1'b0, 32'h0);

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        chk("count_load", count_o, 32'hFFFF_FFFF);
        repeat (3) cycle();
        chk("count_hold", count_o, 32'hFFFF_FFFF);
        cycle();
        chk("count_wrap", count_o, 32'h0);

        // mid-operation reset
        mtc0(5'd11, 32'd2);
        repeat (12) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_timer", {31'b0, timer_int_o}, 32'd0);
        rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.we_i = ($urandom_range(0, 2) == 0);
            bus.waddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(8, 16));
            bus.data_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
            bus.raddr_i = 5'($urandom_range(0, 31));
            bus.excepttype_i = ets[$urandom_range(0, 13)];
            bus.current_inst_addr_i = $urandom;
            bus.is_in_delayslot_i = 1'($urandom_range(0, 1));
            bus.badvaddr_i = $urandom;
            int_in = 6'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
